// File: rtl/serial_rr_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_rr_deserializer: N serial links share one round-robin deserializer.  |
// | Optional stall abort via SER_RR_DESER_TIMEOUT_EN.   Rev 1.0                 |
// +----------------------------------------------------------------------------+
module serial_rr_deserializer #(
  parameter int N       = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid_i,
  input  logic [N-1:0]         req_data_i,
  output logic [N-1:0]         req_ready_o,
  output logic                 par_valid_o,
  output logic [WIDTH-1:0]     par_data_o,
  output logic [$clog2(N)-1:0] par_src_o,
  output logic                 err_timeout_o
);

  localparam int SRC_W = $clog2(N);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [SRC_W:0] N_EXT = (SRC_W+1)'(N);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   owner_q, owner_d, ptr_q, ptr_d, par_src_q, par_src_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d, par_data_q, par_data_d;
  logic               par_valid_q, par_valid_d;

  logic               found;
  logic [SRC_W-1:0]   win, sel;
  logic [SRC_W:0]     idx;
  logic [CNT_W-1:0]   cnt_eff;
  logic [WIDTH-1:0]   word;
  logic               accept;

  function automatic logic [SRC_W-1:0] rr_next(input logic [SRC_W-1:0] i);
    return (i == SRC_W'(N-1)) ? '0 : i + 1'b1;
  endfunction

  // Rotating search starting at ptr: first valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (SRC_W+1)'(k);
      if (idx >= N_EXT) idx = idx - N_EXT;
      if (!found && req_valid_i[idx[SRC_W-1:0]]) begin
        found = 1'b1;
        win   = idx[SRC_W-1:0];
      end
    end
  end

`ifdef SER_RR_DESER_TIMEOUT_EN
  localparam int ST_W = $clog2(TIMEOUT + 1);
  logic [ST_W-1:0] stall_q, stall_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    shreg_d     = shreg_q;
    par_valid_d = 1'b0;
    par_data_d  = par_data_q;
    par_src_d   = par_src_q;
    req_ready_o = '0;
    sel         = owner_q;
    cnt_eff     = cnt_q;
`ifdef SER_RR_DESER_TIMEOUT_EN
    stall_d     = stall_q;
    err_d       = 1'b0;
`endif
    if (state_q == IDLE) begin
      sel     = win;
      cnt_eff = '0;
      if (found) req_ready_o[win] = 1'b1;
    end else begin
      req_ready_o[owner_q] = 1'b1;
    end
    accept = |(req_valid_i & req_ready_o);

    // LSB-first: the k-th accepted bit lands at position k.
    word = shreg_q;
    for (int b = 0; b < WIDTH; b++)
      if (b == int'(cnt_eff)) word[b] = req_data_i[sel];

    if (accept) begin
      shreg_d = word;
      owner_d = sel;
`ifdef SER_RR_DESER_TIMEOUT_EN
      stall_d = '0;
`endif
      if (int'(cnt_eff) == WIDTH - 1) begin
        par_valid_d = 1'b1;
        par_data_d  = word;
        par_src_d   = sel;
        ptr_d       = rr_next(sel);
        cnt_d       = '0;
        state_d     = IDLE;
      end else begin
        cnt_d   = cnt_eff + 1'b1;
        state_d = BUSY;
      end
    end
`ifdef SER_RR_DESER_TIMEOUT_EN
    else if (state_q == BUSY) begin
      stall_d = stall_q + 1'b1;
      if (int'(stall_q) == TIMEOUT - 1) begin
        err_d     = 1'b1;
        par_src_d = owner_q;
        ptr_d     = rr_next(owner_q);
        cnt_d     = '0;
        stall_d   = '0;
        state_d   = IDLE;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      shreg_q     <= '0;
      par_valid_q <= 1'b0;
      par_data_q  <= '0;
      par_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      shreg_q     <= shreg_d;
      par_valid_q <= par_valid_d;
      par_data_q  <= par_data_d;
      par_src_q   <= par_src_d;
    end
  end

`ifdef SER_RR_DESER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end
  assign err_timeout_o = err_q;
`else
  assign err_timeout_o = (TIMEOUT < 0);
`endif

  assign par_valid_o = par_valid_q;
  assign par_data_o  = par_data_q;
  assign par_src_o   = par_src_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_rr_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_serial_rr_deserializer: word-level model plus directed scenarios.        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_serial_rr_deserializer;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic       clk, rst;
  logic [3:0] req_valid, req_data, req_ready;
  logic       par_valid, err_timeout;
  logic [7:0] par_data;
  logic [1:0] par_src;

  logic [1:0] vb, db, rdyb;
  logic       pvb, errb;
  logic [0:0] pdb, psb;

  serial_rr_deserializer #(.N(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .par_valid_o(par_valid), .par_data_o(par_data),
    .par_src_o(par_src), .err_timeout_o(err_timeout));

  serial_rr_deserializer #(.N(2), .WIDTH(1), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rst(rst), .req_valid_i(vb), .req_data_i(db),
    .req_ready_o(rdyb), .par_valid_o(pvb), .par_data_o(pdb),
    .par_src_o(psb), .err_timeout_o(errb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit en    = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Word-level model: who owns the link, how many bits it has delivered.
  int         m_owner = -1;
  int         m_bits  = 0;
  int         m_ptr   = 0;
  int         m_stall = 0;
  logic [7:0] m_word  = '0;
  logic       m_pv = 1'b0, m_err = 1'b0;
  logic [7:0] m_pd = '0;
  logic [1:0] m_ps = '0;

  function automatic logic [3:0] model_ready(input logic [3:0] v);
    if (m_owner >= 0) return 4'(1 << m_owner);
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return 4'(1 << ((m_ptr + k) % N));
    return 4'b0000;
  endfunction

  always @(posedge clk) begin
    logic [3:0] r;
    int         i;
    r = model_ready(req_valid);
    i = 0;
    for (int k = 0; k < N; k++) if (r[k]) i = k;
    m_pv  = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      m_owner = -1; m_bits = 0; m_ptr = 0; m_stall = 0; m_word = '0;
      m_pd = '0; m_ps = '0;
    end else if ((req_valid & r) != 4'b0000) begin
      if (m_owner < 0) begin
        m_owner = i; m_bits = 0; m_word = '0;
      end
      m_stall = 0;
      m_word  = m_word | (8'(req_data[i]) << m_bits);
      m_bits++;
      if (m_bits == W) begin
        m_pv = 1'b1; m_pd = m_word; m_ps = 2'(i);
        m_ptr = (i + 1) % N; m_owner = -1;
      end
    end
`ifdef SER_RR_DESER_TIMEOUT_EN
    else if (m_owner >= 0) begin
      m_stall++;
      if (m_stall == TO) begin
        m_err = 1'b1; m_ps = 2'(m_owner);
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_stall = 0;
      end
    end
`endif
  end

  logic [1:0] obs_src[$];
  logic [7:0] obs_data[$];

  always @(negedge clk) begin
    if (en) begin
      chk("ready", 32'(req_ready), 32'(model_ready(req_valid)));
      chk("onehot", 32'($onehot0(req_ready)), 32'd1);
      chk("pvalid", 32'(par_valid), 32'(m_pv));
      chk("pdata", 32'(par_data), 32'(m_pd));
      chk("psrc", 32'(par_src), 32'(m_ps));
      chk("err", 32'(err_timeout), 32'(m_err));
      if (par_valid) begin
        obs_src.push_back(par_src);
        obs_data.push_back(par_data);
      end
    end
  end

  logic [7:0] wd[4];
  int         sb[4];

  task automatic run(input logic [3:0] v, input int n);
    for (int c = 0; c < n; c++) begin
      logic [3:0] rdy;
      req_valid = v;
      for (int i = 0; i < 4; i++) req_data[i] = wd[i][sb[i]];
      #1 rdy = req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++)
        if (v[i] && rdy[i] && !rst) sb[i] = (sb[i] + 1) % 8;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(4'b0000, 2);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) sb[i] = 0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; vb = '0; db = '0;
    for (int i = 0; i < 4; i++) begin wd[i] = '0; sb[i] = 0; end
    do_reset();
    en = 1'b1;
    chk("rst_pvalid", 32'(par_valid), 32'd0);
    chk("rst_pdata", 32'(par_data), 32'd0);
    chk("rst_psrc", 32'(par_src), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);

    // Single requester 2 sends 1,0,1,1,0,0,1,0.
    wd[2] = 8'h4D;
    run(4'b0100, 8);
    chk("t1_pvalid", 32'(par_valid), 32'd1);
    chk("t1_pdata", 32'(par_data), 32'h4D);
    chk("t1_psrc", 32'(par_src), 32'd2);
    chk("t1_model", 32'(m_pd), 32'h4D);
    req_valid = 4'b1111;
    #1 chk("t1_ptr3", 32'(req_ready), 32'b1000);

    // All four continuously valid: back-to-back rotation.
    for (int i = 0; i < 4; i++) wd[i] = 8'h10 + 8'(i);
    do_reset();
    obs_src.delete(); obs_data.delete();
    run(4'b1111, 40);
    run(4'b0000, 1);
    chk("t2_count", 32'(obs_src.size()), 32'd5);
    if (obs_src.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("t2_src", 32'(obs_src[k]), 32'(k % 4));
        chk("t2_data", 32'(obs_data[k]), 32'h10 + 32'(k % 4));
      end
    end

    // Bubbles on owner 1 while 0 and 3 wait.
    wd[0] = 8'h5A; wd[1] = 8'hA6; wd[3] = 8'hC3;
    do_reset();
    run(4'b0010, 4);
    run(4'b1001, 3);
    #1 chk("t3_hold", 32'(req_ready), 32'b0010);
    run(4'b1011, 4);
    chk("t3_pvalid", 32'(par_valid), 32'd1);
    chk("t3_pdata", 32'(par_data), 32'hA6);
    chk("t3_psrc", 32'(par_src), 32'd1);
    req_valid = 4'b1001;
    #1 chk("t3_next3", 32'(req_ready), 32'b1000);
    run(4'b1001, 8);
    chk("t3_w3", 32'(par_data), 32'hC3);
    chk("t3_s3", 32'(par_src), 32'd3);

    // Reset mid-word.
    wd[0] = 8'hFF;
    do_reset();
    run(4'b0001, 5);
    obs_src.delete(); obs_data.delete();
    rst = 1'b1;
    run(4'b0001, 2);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) sb[i] = 0;
    req_valid = 4'b0011;
    #1 chk("t4_grant0", 32'(req_ready), 32'b0001);
    run(4'b0011, 1);
    run(4'b0000, 2);
    chk("t4_noword", 32'(obs_src.size()), 32'd0);

    // Stall of owner 3 after two bits.
    wd[3] = 8'h03;
    do_reset();
    run(4'b1000, 2);
    run(4'b0001, 15);
    #1 chk("t6_hold", 32'(req_ready), 32'b1000);
    run(4'b0001, 1);
`ifdef SER_RR_DESER_TIMEOUT_EN
    chk("t6_err", 32'(err_timeout), 32'd1);
    chk("t6_psrc", 32'(par_src), 32'd3);
    chk("t6_nopv", 32'(par_valid), 32'd0);
    #1 chk("t6_next0", 32'(req_ready), 32'b0001);
    run(4'b0000, 1);
    chk("t6_pulse", 32'(err_timeout), 32'd0);
`else
    chk("t6_err0", 32'(err_timeout), 32'd0);
    #1 chk("t6_still3", 32'(req_ready), 32'b1000);
`endif

    // WIDTH=1, N=2: both always valid, req0 sends 1, req1 sends 0.
    do_reset();
    vb = 2'b11; db = 2'b01;
    #1 chk("tb_first", 32'(rdyb), 32'b01);
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      chk("tb_pv", 32'(pvb), 32'd1);
      chk("tb_pd", 32'(pdb), (t % 2 == 0) ? 32'd1 : 32'd0);
      chk("tb_ps", 32'(psb), 32'(t % 2));
      chk("tb_rdy", 32'(rdyb), (t % 2 == 0) ? 32'b10 : 32'b01);
      chk("tb_err", 32'(errb), 32'd0);
    end
    vb = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
